// File: rtl/multi_hand_datapath_pkg.sv
// -----------------------------------------------------------------------------
// hand_pkg
// Shared types and helpers for the card-hand datapath.
//   card_t      : 4-bit card rank, 1=A .. 13=K, 0 = empty slot
//   state_t     : datapath control states (READY accepts deals, CLEAR wipes)
//   CARD_MIN/MAX: legal rank range
//   card_value(): baccarat-style point value of a rank (0..9)
// -----------------------------------------------------------------------------
package hand_pkg;

  typedef logic [3:0] card_t;

  typedef enum logic {
    READY = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam card_t CARD_MIN = 4'd1;
  localparam card_t CARD_MAX = 4'd13;

  // Ranks 1..9 score face value; 10 and the court cards score nothing.
  function automatic card_t card_value(input card_t c);
    if (c >= CARD_MIN && c <= 4'd9) begin
      return c;
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/multi_hand_datapath_if.sv
// -----------------------------------------------------------------------------
// multi_hand_datapath_if
// Deal port and hand-state bus between the card source / game controller
// (master) and the hand datapath (slave).
//   new_hand, deal_valid, deal_hand, card_in : master -> datapath
//   deal_ready, deal_error                    : datapath -> master
//   card_out, score_out, hand_count, hand_full: datapath -> master
// -----------------------------------------------------------------------------
interface multi_hand_datapath_if
  import hand_pkg::*;
#(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3
);

  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
  localparam int CW = $clog2(CARDS_PER_HAND + 1);

  logic                                  new_hand;
  logic                                  deal_valid;
  logic [HW-1:0]                         deal_hand;
  card_t                                 card_in;
  logic                                  deal_ready;
  logic                                  deal_error;
  logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] card_out;
  logic [NUM_HANDS*4-1:0]                score_out;
  logic [NUM_HANDS*CW-1:0]               hand_count;
  logic [NUM_HANDS-1:0]                  hand_full;

  modport master (
    output new_hand, deal_valid, deal_hand, card_in,
    input  deal_ready, deal_error, card_out, score_out, hand_count, hand_full
  );

  modport slave (
    input  new_hand, deal_valid, deal_hand, card_in,
    output deal_ready, deal_error, card_out, score_out, hand_count, hand_full
  );

endinterface

// File: rtl/multi_hand_datapath_card_slot.sv
// -----------------------------------------------------------------------------
// card_slot_reg
// One 4-bit card slot: load-enable register with synchronous clear.
//   clk_i  : clock (rising edge)
//   rst_ni : synchronous active-low reset
//   clr_i  : synchronous clear (wins over load)
//   ld_i   : load d_i
//   d_i    : card to store
//   q_o    : stored card, 0 = empty
// -----------------------------------------------------------------------------
module card_slot_reg
  import hand_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,
  input  logic  ld_i,
  input  card_t d_i,
  output card_t q_o
);

  card_t slot_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      slot_q <= '0;
    end else if (clr_i) begin
      slot_q <= '0;
    end else if (ld_i) begin
      slot_q <= d_i;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/multi_hand_datapath.sv
// -----------------------------------------------------------------------------
// multi_hand_datapath
// Holds NUM_HANDS hands of up to CARDS_PER_HAND cards, accepts cards over a
// valid/ready deal port and keeps a registered mod-10 score per hand.
//   slow_clock : sole clock, rising edge
//   resetb     : synchronous active-low reset
//   dp         : multi_hand_datapath_if.slave (deal port + hand state outputs)
// Optional build macro SHOE_TRACK_EN: per-rank dealt counters that reject a
// rank once 4*DECKS of it have been dealt since reset.
// -----------------------------------------------------------------------------
module multi_hand_datapath
  import hand_pkg::*;
#(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int DECKS          = 1
) (
  input logic                   slow_clock,
  input logic                   resetb,
  multi_hand_datapath_if.slave  dp
);

  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1;
  localparam int CW = $clog2(CARDS_PER_HAND + 1);

  // Score accumulate on a 5-bit intermediate, folding back once past 9.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

  state_t        state_q;
  logic [HW-1:0] clr_idx_q;
  logic          ready_q;
  logic          err_q;

  logic [CW-1:0] cnt_q   [NUM_HANDS];
  logic [CW-1:0] cnt_d   [NUM_HANDS];
  logic [3:0]    score_q [NUM_HANDS];
  logic [3:0]    score_d [NUM_HANDS];

  logic                 offer;
  logic                 hand_ok;
  logic                 rank_ok;
  logic                 room_ok;
  logic                 shoe_ok;
  logic                 accept;
  logic                 reject;
  logic [CW-1:0]        tgt_cnt;
  logic [NUM_HANDS-1:0] clr_hit;
  logic [NUM_HANDS-1:0] ld_hit;

  // Deal validation
  always_comb begin
    offer   = (state_q == READY) && dp.deal_valid && !dp.new_hand;
    hand_ok = ({1'b0, dp.deal_hand} < (HW + 1)'(NUM_HANDS));
    rank_ok = (dp.card_in >= CARD_MIN) && (dp.card_in <= CARD_MAX);
    tgt_cnt = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (dp.deal_hand == HW'(h)) begin
        tgt_cnt = cnt_q[h];
      end
    end
    room_ok = hand_ok && (tgt_cnt != CW'(CARDS_PER_HAND));
    accept  = offer && hand_ok && rank_ok && room_ok && shoe_ok;
    reject  = offer && !(hand_ok && rank_ok && room_ok && shoe_ok);
  end

`ifdef SHOE_TRACK_EN
  localparam int SW = $clog2(4 * DECKS + 1);

  logic [SW-1:0] shoe_q [13];

  // Rank exhausted once every copy in the shoe has been dealt.
  always_comb begin
    shoe_ok = 1'b1;
    for (int r = 0; r < 13; r++) begin
      if (dp.card_in == 4'(r + 1) && shoe_q[r] == SW'(4 * DECKS)) begin
        shoe_ok = 1'b0;
      end
    end
  end

  // Only resetb empties the shoe record; new_hand leaves it intact.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int r = 0; r < 13; r++) begin
        shoe_q[r] <= '0;
      end
    end else if (accept) begin
      for (int r = 0; r < 13; r++) begin
        if (dp.card_in == 4'(r + 1)) begin
          shoe_q[r] <= shoe_q[r] + SW'(1);
        end
      end
    end
  end
`else
  logic unused_decks;
  assign unused_decks = (DECKS > 0);
  assign shoe_ok      = 1'b1;
`endif

  // Control FSM: READY <-> CLEAR, registered ready/error outputs
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q   <= READY;
      clr_idx_q <= '0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      err_q <= reject;
      case (state_q)
        READY: begin
          if (dp.new_hand) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_idx_q == HW'(NUM_HANDS - 1)) begin
            state_q   <= READY;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + HW'(1);
          end
        end
        default: begin
          state_q <= READY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Per-hand count/score next state
  always_comb begin
    clr_hit = '0;
    ld_hit  = '0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      cnt_d[h]   = cnt_q[h];
      score_d[h] = score_q[h];
      if (state_q == CLEAR && clr_idx_q == HW'(h)) begin
        clr_hit[h] = 1'b1;
        cnt_d[h]   = '0;
        score_d[h] = '0;
      end else if (accept && dp.deal_hand == HW'(h)) begin
        ld_hit[h]  = 1'b1;
        cnt_d[h]   = cnt_q[h] + CW'(1);
        score_d[h] = add_mod10(score_q[h], card_value(dp.card_in));
      end
    end
  end

  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        cnt_q[h]   <= '0;
        score_q[h] <= '0;
      end
    end else begin
      for (int h = 0; h < NUM_HANDS; h++) begin
        cnt_q[h]   <= cnt_d[h];
        score_q[h] <= score_d[h];
      end
    end
  end

  // Slot storage: an accepted card lands in the slot indexed by the current count
  for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
    for (genvar s = 0; s < CARDS_PER_HAND; s++) begin : g_slot
      card_t slot_card;

      card_slot_reg u_slot (
        .clk_i  (slow_clock),
        .rst_ni (resetb),
        .clr_i  (clr_hit[h]),
        .ld_i   (ld_hit[h] && (cnt_q[h] == CW'(s))),
        .d_i    (dp.card_in),
        .q_o    (slot_card)
      );

      assign dp.card_out[(h*CARDS_PER_HAND+s)*4 +: 4] = slot_card;
    end

    assign dp.score_out[h*4 +: 4]   = score_q[h];
    assign dp.hand_count[h*CW +: CW] = cnt_q[h];
    assign dp.hand_full[h]           = (cnt_q[h] == CW'(CARDS_PER_HAND));
  end

  assign dp.deal_ready = ready_q;
  assign dp.deal_error = err_q;

endmodule

// File: tb/tb_multi_hand_datapath.sv
module tb_multi_hand_datapath;
  import hand_pkg::*;

  localparam int NH    = 3;
  localparam int CPH   = 3;
  localparam int DECKS = 1;
  localparam int HW    = 2;
  localparam int CW    = 2;

  logic slow_clock = 1'b0;
  logic resetb     = 1'b0;
  always #5 slow_clock = ~slow_clock;

  multi_hand_datapath_if #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH)) dp ();

  multi_hand_datapath #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH), .DECKS(DECKS)) dut (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .dp         (dp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: hands as plain arrays, clear as a countdown
  int m_slot [NH][CPH];
  int m_cnt  [NH];
  int m_err;
  int clear_left;
  int shoe   [16];

  function automatic int val(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction

  function automatic logic [NH*CPH*4-1:0] exp_cards();
    logic [NH*CPH*4-1:0] r = '0;
    for (int h = 0; h < NH; h++)
      for (int s = 0; s < CPH; s++) r[(h*CPH+s)*4 +: 4] = 4'(m_slot[h][s]);
    return r;
  endfunction

  function automatic logic [NH*4-1:0] exp_scores();
    logic [NH*4-1:0] r = '0;
    for (int h = 0; h < NH; h++) begin
      int sum = 0;
      for (int s = 0; s < CPH; s++) sum += val(m_slot[h][s]);
      r[h*4 +: 4] = 4'(sum % 10);
    end
    return r;
  endfunction

  function automatic logic [NH*CW-1:0] exp_counts();
    logic [NH*CW-1:0] r = '0;
    for (int h = 0; h < NH; h++) r[h*CW +: CW] = CW'(m_cnt[h]);
    return r;
  endfunction

  function automatic logic [NH-1:0] exp_full();
    logic [NH-1:0] r = '0;
    for (int h = 0; h < NH; h++) r[h] = (m_cnt[h] == CPH);
    return r;
  endfunction

  // Drive one clock edge worth of inputs, advance the model, settle past the edge
  task automatic step(input logic nh, input logic v, input int h, input int c, input logic rb);
    bit ok;
    dp.new_hand   = nh;
    dp.deal_valid = v;
    dp.deal_hand  = HW'(h);
    dp.card_in    = 4'(c);
    resetb        = rb;
    if (!rb) begin
      for (int i = 0; i < NH; i++) begin
        m_cnt[i] = 0;
        for (int s = 0; s < CPH; s++) m_slot[i][s] = 0;
      end
      for (int r = 0; r < 16; r++) shoe[r] = 0;
      m_err = 0;
      clear_left = 0;
    end else begin
      m_err = 0;
      if (clear_left > 0) begin
        int ch = NH - clear_left;
        m_cnt[ch] = 0;
        for (int s = 0; s < CPH; s++) m_slot[ch][s] = 0;
        clear_left--;
      end else if (nh) begin
        clear_left = NH;
      end else if (v) begin
        ok = (h < NH) && (c >= 1) && (c <= 13);
        if (ok) ok = (m_cnt[h] < CPH);
`ifdef SHOE_TRACK_EN
        if (ok) ok = (shoe[c] < 4 * DECKS);
`endif
        if (ok) begin
          m_slot[h][m_cnt[h]] = c;
          m_cnt[h]++;
          shoe[c]++;
        end else begin
          m_err = 1;
        end
      end
    end
    @(posedge slow_clock);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 0, 5, 1'b0);
    checks++; if (dp.deal_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", dp.deal_ready); end
    checks++; if (dp.deal_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", dp.deal_error); end
    checks++; if (dp.card_out !== '0) begin errors++; $display("FAIL reset_cards got %h exp 0", dp.card_out); end
    checks++; if (dp.score_out !== '0 || dp.hand_count !== '0 || dp.hand_full !== '0) begin
      errors++; $display("FAIL reset_hand got score %h count %h full %b exp 0", dp.score_out, dp.hand_count, dp.hand_full); end
  endtask

  task automatic test_deals();
    step(1'b0, 1'b1, 0, 7, 1'b1);
    step(1'b0, 1'b1, 0, 8, 1'b1);
    checks++; if (dp.score_out[3:0] !== 4'd5) begin errors++; $display("FAIL deal_score0 got %0d exp 5", dp.score_out[3:0]); end
    checks++; if (dp.hand_count[1:0] !== 2'd2) begin errors++; $display("FAIL deal_count0 got %0d exp 2", dp.hand_count[1:0]); end
    checks++; if (dp.card_out[11:0] !== 12'h087) begin errors++; $display("FAIL deal_slots0 got %h exp 087", dp.card_out[11:0]); end
    checks++; if (dp.deal_error !== 1'b0) begin errors++; $display("FAIL deal_noerr got %b exp 0", dp.deal_error); end
  endtask

  task automatic test_fill_overflow();
    logic [NH*CPH*4-1:0] snap;
    step(1'b0, 1'b1, 1, 13, 1'b1);
    step(1'b0, 1'b1, 1, 9, 1'b1);
    step(1'b0, 1'b1, 1, 3, 1'b1);
    checks++; if (dp.score_out[7:4] !== 4'd2) begin errors++; $display("FAIL fill_score1 got %0d exp 2", dp.score_out[7:4]); end
    checks++; if (dp.hand_full !== 3'b010) begin errors++; $display("FAIL fill_full got %b exp 010", dp.hand_full); end
    snap = dp.card_out;
    step(1'b0, 1'b1, 1, 5, 1'b1);
    checks++; if (dp.deal_error !== 1'b1) begin errors++; $display("FAIL over_err got %b exp 1", dp.deal_error); end
    checks++; if (dp.card_out !== snap || dp.hand_count !== exp_counts()) begin
      errors++; $display("FAIL over_nochange got %h/%h exp %h/%h", dp.card_out, dp.hand_count, snap, exp_counts()); end
    step(1'b0, 1'b0, 0, 0, 1'b1);
    checks++; if (dp.deal_error !== 1'b0) begin errors++; $display("FAIL over_pulse got %b exp 0", dp.deal_error); end
  endtask

  task automatic test_invalid();
    int hs [3] = '{0, 0, 3};
    int cs [3] = '{0, 14, 5};
    logic [NH*CPH*4-1:0] snap;
    logic [NH*4-1:0]     ssnap;
    for (int i = 0; i < 3; i++) begin
      snap  = dp.card_out;
      ssnap = dp.score_out;
      step(1'b0, 1'b1, hs[i], cs[i], 1'b1);
      checks++; if (dp.deal_error !== 1'b1) begin errors++; $display("FAIL inv_err%0d got %b exp 1", i, dp.deal_error); end
      checks++; if (dp.card_out !== snap || dp.score_out !== ssnap) begin
        errors++; $display("FAIL inv_state%0d got %h/%h exp %h/%h", i, dp.card_out, dp.score_out, snap, ssnap); end
      step(1'b0, 1'b0, 0, 0, 1'b1);
      checks++; if (dp.deal_error !== 1'b0) begin errors++; $display("FAIL inv_pulse%0d got %b exp 0", i, dp.deal_error); end
    end
  endtask

  task automatic test_new_hand();
    step(1'b1, 1'b1, 0, 4, 1'b1);
    checks++; if (dp.deal_ready !== 1'b0 || dp.deal_error !== 1'b0) begin
      errors++; $display("FAIL nh_enter got ready %b err %b exp 0 0", dp.deal_ready, dp.deal_error); end
    for (int i = 1; i < NH; i++) begin
      step(1'b1, 1'b1, 2, 6, 1'b1);
      checks++; if (dp.deal_ready !== 1'b0 || dp.deal_error !== 1'b0) begin
        errors++; $display("FAIL nh_clear%0d got ready %b err %b exp 0 0", i, dp.deal_ready, dp.deal_error); end
    end
    step(1'b0, 1'b1, 2, 6, 1'b1);
    checks++; if (dp.deal_ready !== 1'b1) begin errors++; $display("FAIL nh_ready got %b exp 1", dp.deal_ready); end
    checks++; if (dp.card_out !== '0 || dp.score_out !== '0 || dp.hand_count !== '0 || dp.hand_full !== '0) begin
      errors++; $display("FAIL nh_cleared got %h %h %h %b exp all 0", dp.card_out, dp.score_out, dp.hand_count, dp.hand_full); end
    step(1'b0, 1'b1, 2, 6, 1'b1);
    checks++; if (dp.hand_count !== 6'b010000 || dp.score_out !== 12'h600) begin
      errors++; $display("FAIL nh_first got count %b score %h exp 010000 600", dp.hand_count, dp.score_out); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0, 0, 1'b0);
    checks++; if (dp.deal_ready !== 1'b1 || dp.card_out !== '0 || dp.score_out !== '0 || dp.hand_count !== '0) begin
      errors++; $display("FAIL rst_clear got ready %b cards %h score %h exp 1 0 0", dp.deal_ready, dp.card_out, dp.score_out); end
    step(1'b0, 1'b1, 0, 3, 1'b1);
    step(1'b0, 1'b1, 1, 4, 1'b1);
    step(1'b0, 1'b1, 2, 5, 1'b0);
    checks++; if (dp.deal_ready !== 1'b1 || dp.card_out !== '0 || dp.score_out !== '0 || dp.hand_count !== '0 || dp.deal_error !== 1'b0) begin
      errors++; $display("FAIL rst_deal got ready %b cards %h score %h err %b exp 1 0 0 0", dp.deal_ready, dp.card_out, dp.score_out, dp.deal_error); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2, 9, 1'b1);
      checks++; if (dp.hand_count !== exp_counts() || dp.score_out !== exp_scores() || dp.card_out !== exp_cards()) begin
        errors++; $display("FAIL b2b%0d got %h %h %h exp %h %h %h", i, dp.hand_count, dp.score_out, dp.card_out, exp_counts(), exp_scores(), exp_cards()); end
    end
    checks++; if (dp.score_out[11:8] !== 4'd7 || dp.hand_full[2] !== 1'b1) begin
      errors++; $display("FAIL b2b_final got score %0d full %b exp 7 1", dp.score_out[11:8], dp.hand_full[2]); end
  endtask

`ifdef SHOE_TRACK_EN
  task automatic test_shoe();
    step(1'b0, 1'b0, 0, 0, 1'b0);
    for (int h = 0; h < NH; h++) step(1'b0, 1'b1, h, 5, 1'b1);
    step(1'b1, 1'b0, 0, 0, 1'b1);
    for (int i = 0; i < NH; i++) step(1'b0, 1'b0, 0, 0, 1'b1);
    step(1'b0, 1'b1, 0, 5, 1'b1);
    checks++; if (dp.deal_error !== 1'b0 || dp.hand_count[1:0] !== 2'd1) begin
      errors++; $display("FAIL shoe_fourth got err %b count %0d exp 0 1", dp.deal_error, dp.hand_count[1:0]); end
    step(1'b0, 1'b1, 1, 5, 1'b1);
    checks++; if (dp.deal_error !== 1'b1 || dp.hand_count[3:2] !== 2'd0) begin
      errors++; $display("FAIL shoe_fifth got err %b count %0d exp 1 0", dp.deal_error, dp.hand_count[3:2]); end
  endtask
`endif

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic nh, v, rb;
      nh = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 3) != 0);
      rb = ($urandom_range(0, 79) != 0);
      step(nh, v, $urandom_range(0, 3), $urandom_range(0, 15), rb);
      checks++; if (dp.card_out !== exp_cards()) begin errors++; $display("FAIL rnd_cards c%0d got %h exp %h", cyc, dp.card_out, exp_cards()); end
      checks++; if (dp.score_out !== exp_scores()) begin errors++; $display("FAIL rnd_score c%0d got %h exp %h", cyc, dp.score_out, exp_scores()); end
      checks++; if (dp.hand_count !== exp_counts() || dp.hand_full !== exp_full()) begin
        errors++; $display("FAIL rnd_count c%0d got %h/%b exp %h/%b", cyc, dp.hand_count, dp.hand_full, exp_counts(), exp_full()); end
      checks++; if (dp.deal_ready !== (clear_left == 0) || dp.deal_error !== m_err[0]) begin
        errors++; $display("FAIL rnd_ctrl c%0d got ready %b err %b exp %b %b", cyc, dp.deal_ready, dp.deal_error, clear_left == 0, m_err[0]); end
    end
  endtask

  initial begin
    dp.new_hand   = 1'b0;
    dp.deal_valid = 1'b0;
    dp.deal_hand  = '0;
    dp.card_in    = '0;
    test_reset();
    test_deals();
    test_fill_overflow();
    test_invalid();
    test_new_hand();
    test_reset_mid();
    test_back_to_back();
`ifdef SHOE_TRACK_EN
    test_shoe();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
